// File: rtl/alu0_exec_pipe.sv
// alu0_exec_pipe
// Two-stage execute pipe sitting behind the ALU0 issue queue.
//   S1: holds the selected instruction, reads its operands (with bypass from
//       S2) and computes the ALU result combinationally.
//   S2: holds the result until the writeback port accepts it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kills both stages and any select in this cycle
//   ALU0_select_*             instruction chosen by the ALU0 issue queue
//   ALU0_IQ_pause             backpressure to the issue queue
//   dest_ALU0_vld, dest_ALU0  wakeup tag broadcast to all issue queues
//   rf_raddr1/2, rf_rdata1/2  asynchronous regfile read port
//   wb_vld, wb_rdy            writeback / ROB-complete handshake
//   wb_dest, wb_data, wb_ROB_ID  writeback payload
module alu0_exec_pipe #(
    parameter int PR_W  = 7,
    parameter int ROB_W = 6,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ALU0_select_vld,
    input  logic [4:0]       ALU0_select_op,
    input  logic [19:0]      ALU0_select_imm,
    input  logic [PR_W-1:0]  ALU0_select_dest,
    input  logic [PR_W-1:0]  ALU0_select_source1,
    input  logic [PR_W-1:0]  ALU0_select_source2,
    input  logic [ROB_W-1:0] ALU0_select_ROB_ID,
    output logic             ALU0_IQ_pause,
    output logic             dest_ALU0_vld,
    output logic [PR_W-1:0]  dest_ALU0,
    output logic [PR_W-1:0]  rf_raddr1,
    output logic [PR_W-1:0]  rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    output logic             wb_vld,
    input  logic             wb_rdy,
    output logic [PR_W-1:0]  wb_dest,
    output logic [XLEN-1:0]  wb_data,
    output logic [ROB_W-1:0] wb_ROB_ID
);

    // S1 payload
    logic             s1_vld;
    logic [4:0]       s1_op;
    logic [19:0]      s1_imm;
    logic [PR_W-1:0]  s1_dest;
    logic [PR_W-1:0]  s1_src1;
    logic [PR_W-1:0]  s1_src2;
    logic [ROB_W-1:0] s1_rob;

    // S2 payload
    logic             s2_vld;
    logic [PR_W-1:0]  s2_dest;
    logic [XLEN-1:0]  s2_data;
    logic [ROB_W-1:0] s2_rob;

    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  imm_zext;
    logic [4:0]       sh_reg;
    logic [4:0]       sh_imm;
    logic [XLEN-1:0]  result;

    assign ALU0_IQ_pause = s2_vld & ~wb_rdy;

    assign dest_ALU0_vld = s1_vld & ~ALU0_IQ_pause & ~flush;
    assign dest_ALU0     = s1_dest;

    assign rf_raddr1 = s1_src1;
    assign rf_raddr2 = s1_src2;

    assign wb_vld    = s2_vld & ~flush;
    assign wb_dest   = s2_dest;
    assign wb_data   = s2_data;
    assign wb_ROB_ID = s2_rob;

    // The producer one stage ahead has not reached the regfile yet, so its
    // result is forwarded from S2 even while writeback is stalled. Register 0
    // is hardwired and never forwarded.
    assign op_a = (s2_vld && (s2_dest == s1_src1) && (s1_src1 != '0)) ? s2_data : rf_rdata1;
    assign op_b = (s2_vld && (s2_dest == s1_src2) && (s1_src2 != '0)) ? s2_data : rf_rdata2;

    assign imm_sext = {{(XLEN-12){s1_imm[11]}}, s1_imm[11:0]};
    assign imm_zext = {{(XLEN-12){1'b0}}, s1_imm[11:0]};
    assign sh_reg   = op_b[4:0];
    assign sh_imm   = s1_imm[4:0];

    always_comb begin
        result = '0;
        case (s1_op)
            5'd0:  result = op_a + op_b;
            5'd1:  result = op_a - op_b;
            5'd2:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            5'd3:  result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            5'd4:  result = op_a & op_b;
            5'd5:  result = op_a | op_b;
            5'd6:  result = ~(op_a | op_b);
            5'd7:  result = op_a ^ op_b;
            5'd8:  result = op_a << sh_reg;
            5'd9:  result = op_a >> sh_reg;
            5'd10: result = $unsigned($signed(op_a) >>> sh_reg);
            5'd11: result = XLEN'({s1_imm, 12'b0});
            5'd12: result = op_a + imm_sext;
            5'd13: result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(imm_sext))};
            5'd14: result = {{(XLEN-1){1'b0}}, (op_a < imm_sext)};
            5'd15: result = op_a & imm_zext;
            5'd16: result = op_a | imm_zext;
            5'd17: result = op_a ^ imm_zext;
            5'd18: result = op_a << sh_imm;
            5'd19: result = op_a >> sh_imm;
            5'd20: result = $unsigned($signed(op_a) >>> sh_imm);
            default: result = '0;
        endcase
    end

    // While paused both stages hold. When not paused, S2 always takes
    // whatever S1 holds (possibly a bubble), which is what lets a new select
    // enter in the same cycle S2 retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_op   <= '0;
            s1_imm  <= '0;
            s1_dest <= '0;
            s1_src1 <= '0;
            s1_src2 <= '0;
            s1_rob  <= '0;
            s2_vld  <= 1'b0;
            s2_dest <= '0;
            s2_data <= '0;
            s2_rob  <= '0;
        end else if (flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (!ALU0_IQ_pause) begin
            s1_vld <= ALU0_select_vld;
            if (ALU0_select_vld) begin
                s1_op   <= ALU0_select_op;
                s1_imm  <= ALU0_select_imm;
                s1_dest <= ALU0_select_dest;
                s1_src1 <= ALU0_select_source1;
                s1_src2 <= ALU0_select_source2;
                s1_rob  <= ALU0_select_ROB_ID;
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dest <= s1_dest;
                s2_data <= result;
                s2_rob  <= s1_rob;
            end
        end
    end

endmodule

// File: tb/tb_alu0_exec_pipe.sv
// Testbench for alu0_exec_pipe: behavioural regfile, reference ALU model and
// a scoreboard of expected writebacks checked in order by a monitor.
module tb_alu0_exec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ALU0_select_vld;
    logic [4:0]  ALU0_select_op;
    logic [19:0] ALU0_select_imm;
    logic [6:0]  ALU0_select_dest;
    logic [6:0]  ALU0_select_source1;
    logic [6:0]  ALU0_select_source2;
    logic [5:0]  ALU0_select_ROB_ID;
    logic        ALU0_IQ_pause;
    logic        dest_ALU0_vld;
    logic [6:0]  dest_ALU0;
    logic [6:0]  rf_raddr1;
    logic [6:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_vld;
    logic        wb_rdy;
    logic [6:0]  wb_dest;
    logic [31:0] wb_data;
    logic [5:0]  wb_ROB_ID;

    alu0_exec_pipe #(.PR_W(7), .ROB_W(6), .XLEN(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .ALU0_select_vld     (ALU0_select_vld),
        .ALU0_select_op      (ALU0_select_op),
        .ALU0_select_imm     (ALU0_select_imm),
        .ALU0_select_dest    (ALU0_select_dest),
        .ALU0_select_source1 (ALU0_select_source1),
        .ALU0_select_source2 (ALU0_select_source2),
        .ALU0_select_ROB_ID  (ALU0_select_ROB_ID),
        .ALU0_IQ_pause       (ALU0_IQ_pause),
        .dest_ALU0_vld       (dest_ALU0_vld),
        .dest_ALU0           (dest_ALU0),
        .rf_raddr1           (rf_raddr1),
        .rf_raddr2           (rf_raddr2),
        .rf_rdata1           (rf_rdata1),
        .rf_rdata2           (rf_rdata2),
        .wb_vld              (wb_vld),
        .wb_rdy              (wb_rdy),
        .wb_dest             (wb_dest),
        .wb_data             (wb_data),
        .wb_ROB_ID           (wb_ROB_ID)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  dest;
        logic [31:0] data;
        logic [5:0]  rob;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    logic [31:0] rf_mem [128];
    logic [31:0] mdl [128];
    logic        ld_en;
    logic [6:0]  ld_addr;
    logic [31:0] ld_data;
    int          n_cmp = 0;
    int          n_err = 0;

    // Regfile: asynchronous read, written by preloads or accepted writebacks.
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    always @(posedge clk) begin
        if (ld_en)
            rf_mem[ld_addr] <= ld_data;
        else if (wb_vld && wb_rdy && wb_dest != 7'd0)
            rf_mem[wb_dest] <= wb_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sra_ref(input logic [31:0] a, input logic [4:0] sh);
        logic [63:0] ext;
        ext = {{32{a[31]}}, a} >> sh;
        return ext[31:0];
    endfunction

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [19:0] imm);
        logic [31:0] se;
        logic [31:0] ze;
        logic [31:0] msb;
        se  = {{20{imm[11]}}, imm[11:0]};
        ze  = {20'h0, imm[11:0]};
        msb = 32'h8000_0000;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a + ~b + 32'd1;
            5'd2:  return {31'd0, ((a ^ msb) < (b ^ msb))};
            5'd3:  return {31'd0, (a < b)};
            5'd4:  return a & b;
            5'd5:  return a | b;
            5'd6:  return ~a & ~b;
            5'd7:  return a ^ b;
            5'd8:  return a << b[4:0];
            5'd9:  return a >> b[4:0];
            5'd10: return sra_ref(a, b[4:0]);
            5'd11: return {imm, 12'h000};
            5'd12: return a + se;
            5'd13: return {31'd0, ((a ^ msb) < (se ^ msb))};
            5'd14: return {31'd0, (a < se)};
            5'd15: return a & ze;
            5'd16: return a | ze;
            5'd17: return a ^ ze;
            5'd18: return a << imm[4:0];
            5'd19: return a >> imm[4:0];
            5'd20: return sra_ref(a, imm[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // In-order writeback checker.
    always @(negedge clk) begin
        if (!rst && wb_vld && wb_rdy) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 64'(wb_vld), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_dest", 64'(wb_dest), 64'(mon_e.dest));
                chk("wb_data", 64'(wb_data), 64'(mon_e.data));
                chk("wb_rob", 64'(wb_ROB_ID), 64'(mon_e.rob));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [6:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        mdl[addr] = data;
        step();
        ld_en = 1'b0;
    endtask

    // Drive one select; when push is set, the expected writeback is queued
    // (fixed value if use_fix, otherwise from the reference model).
    task automatic drive(input logic [4:0] op, input logic [19:0] imm, input logic [6:0] dest,
                         input logic [6:0] s1, input logic [6:0] s2, input logic [5:0] rob,
                         input bit push, input bit use_fix, input logic [31:0] fix);
        logic [31:0] e;
        ALU0_select_vld     = 1'b1;
        ALU0_select_op      = op;
        ALU0_select_imm     = imm;
        ALU0_select_dest    = dest;
        ALU0_select_source1 = s1;
        ALU0_select_source2 = s2;
        ALU0_select_ROB_ID  = rob;
        if (push) begin
            e = use_fix ? fix : alu_ref(op, mdl[s1], mdl[s2], imm);
            sb.push_back('{dest: dest, data: e, rob: rob});
            if (dest != 7'd0) mdl[dest] = e;
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [19:0] imm;
        logic [6:0]  dest;
        logic [6:0]  s1;
        logic [6:0]  s2;
        bit          use_fix;
        logic [31:0] fix;
    } vec_t;

    vec_t vecs[$];

    initial begin
        for (int i = 0; i < 128; i++) mdl[i] = 32'd0;
        rst = 1'b1; flush = 1'b0; wb_rdy = 1'b1;
        ALU0_select_vld = 1'b0; ALU0_select_op = '0; ALU0_select_imm = '0;
        ALU0_select_dest = '0; ALU0_select_source1 = '0; ALU0_select_source2 = '0;
        ALU0_select_ROB_ID = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        ld(7'd0, 32'd0);
        ld(7'd1, 32'd10);
        ld(7'd2, 32'd3);
        ld(7'd10, 32'h8000_0001);
        ld(7'd11, 32'h0000_0004);
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_pause", 64'(ALU0_IQ_pause), 64'd0);
        chk("rst_wake_vld", 64'(dest_ALU0_vld), 64'd0);
        chk("rst_wake_dest", 64'(dest_ALU0), 64'd0);
        chk("rst_raddr", 64'({rf_raddr1, rf_raddr2}), 64'd0);
        chk("rst_wb_vld", 64'(wb_vld), 64'd0);
        chk("rst_wb_payload", 64'({wb_dest, wb_data, wb_ROB_ID}), 64'd0);
        step();

        // back-to-back ADD then dependent ADDI through the bypass
        drive(5'd0, 20'h0, 7'd5, 7'd1, 7'd2, 6'd1, 1, 1, 32'd13);
        step();
        drive(5'd12, 20'h00FFF, 7'd6, 7'd5, 7'd0, 6'd2, 1, 1, 32'd12);
        @(negedge clk);
        chk("b2b_wake_vld0", 64'(dest_ALU0_vld), 64'd1);
        chk("b2b_wake_dest0", 64'(dest_ALU0), 64'd5);
        step();
        ALU0_select_vld = 1'b0;
        @(negedge clk);
        chk("b2b_wake_vld1", 64'(dest_ALU0_vld), 64'd1);
        chk("b2b_wake_dest1", 64'(dest_ALU0), 64'd6);
        chk("b2b_latency_vld", 64'(wb_vld), 64'd1);
        chk("b2b_latency_dest", 64'(wb_dest), 64'd5);
        repeat (3) step();

        // opcode sweep, fixed expectations first then model-driven ones
        vecs.push_back('{5'd2,  20'h0,     7'd12, 7'd10, 7'd11, 1, 32'd1});
        vecs.push_back('{5'd3,  20'h0,     7'd13, 7'd10, 7'd11, 1, 32'd0});
        vecs.push_back('{5'd10, 20'h0,     7'd14, 7'd10, 7'd11, 1, 32'hF800_0000});
        vecs.push_back('{5'd9,  20'h0,     7'd15, 7'd10, 7'd11, 1, 32'h0800_0000});
        vecs.push_back('{5'd6,  20'h0,     7'd16, 7'd10, 7'd11, 1, 32'h7FFF_FFFA});
        vecs.push_back('{5'd11, 20'hABCDE, 7'd17, 7'd0,  7'd0,  1, 32'hABCD_E000});
        vecs.push_back('{5'd1,  20'h0,     7'd18, 7'd11, 7'd10, 0, 32'd0});
        vecs.push_back('{5'd7,  20'h0,     7'd19, 7'd18, 7'd17, 0, 32'd0});
        vecs.push_back('{5'd8,  20'h0,     7'd20, 7'd11, 7'd11, 0, 32'd0});
        vecs.push_back('{5'd4,  20'h0,     7'd21, 7'd10, 7'd19, 0, 32'd0});
        vecs.push_back('{5'd5,  20'h0,     7'd22, 7'd14, 7'd11, 0, 32'd0});
        vecs.push_back('{5'd13, 20'h00800, 7'd23, 7'd11, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd14, 20'h00FFF, 7'd24, 7'd10, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd15, 20'hFFF0F, 7'd25, 7'd17, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd16, 20'h00F00, 7'd26, 7'd11, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd17, 20'h00FFF, 7'd27, 7'd26, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd18, 20'h00003, 7'd28, 7'd27, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd19, 20'h0001F, 7'd29, 7'd10, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd20, 20'h0001F, 7'd30, 7'd10, 7'd0,  0, 32'd0});
        vecs.push_back('{5'd0,  20'h0,     7'd31, 7'd30, 7'd30, 0, 32'd0});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].imm, vecs[i].dest, vecs[i].s1, vecs[i].s2,
                  6'(i + 8), 1, vecs[i].use_fix, vecs[i].fix);
            step();
        end
        ALU0_select_vld = 1'b0;
        repeat (4) step();

        // writeback stall with two ops in flight
        wb_rdy = 1'b0;
        drive(5'd0, 20'h0, 7'd40, 7'd1, 7'd2, 6'd40, 1, 0, 32'd0);
        step();
        drive(5'd7, 20'h0, 7'd41, 7'd1, 7'd2, 6'd41, 1, 0, 32'd0);
        step();
        drive(5'd0, 20'h0, 7'd42, 7'd1, 7'd1, 6'd42, 0, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pause", 64'(ALU0_IQ_pause), 64'd1);
            chk("stall_wb_vld", 64'(wb_vld), 64'd1);
            chk("stall_wb_dest", 64'(wb_dest), 64'd40);
            chk("stall_wb_data", 64'(wb_data), 64'd13);
            chk("stall_wake_vld", 64'(dest_ALU0_vld), 64'd0);
            step();
        end
        ALU0_select_vld = 1'b0;
        wb_rdy = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("stall_nojunk", 64'(wb_vld), 64'd0);
        step();

        // flush with both stages full and a select in the same cycle
        drive(5'd0, 20'h0, 7'd50, 7'd1, 7'd2, 6'd50, 0, 0, 32'd0);
        step();
        drive(5'd0, 20'h0, 7'd51, 7'd1, 7'd2, 6'd51, 0, 0, 32'd0);
        step();
        drive(5'd0, 20'h0, 7'd52, 7'd1, 7'd2, 6'd52, 0, 0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wb_gated", 64'(wb_vld), 64'd0);
        chk("flush_wake_gated", 64'(dest_ALU0_vld), 64'd0);
        step();
        flush = 1'b0;
        ALU0_select_vld = 1'b0;
        @(negedge clk);
        chk("flush_s2_empty", 64'(wb_vld), 64'd0);
        chk("flush_s1_empty", 64'(dest_ALU0_vld), 64'd0);
        step();
        @(negedge clk);
        chk("flush_sel_dropped", 64'(wb_vld), 64'd0);
        step();

        // reset while paused
        wb_rdy = 1'b0;
        drive(5'd0, 20'h12345, 7'd60, 7'd10, 7'd11, 6'h3F, 0, 0, 32'd0);
        step();
        ALU0_select_vld = 1'b0;
        step();
        @(negedge clk);
        chk("rstmid_paused", 64'(ALU0_IQ_pause), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_pause", 64'(ALU0_IQ_pause), 64'd0);
        chk("rstmid_wake", 64'({dest_ALU0_vld, dest_ALU0}), 64'd0);
        chk("rstmid_raddr", 64'({rf_raddr1, rf_raddr2}), 64'd0);
        chk("rstmid_wb_vld", 64'(wb_vld), 64'd0);
        chk("rstmid_wb_payload", 64'({wb_dest, wb_data, wb_ROB_ID}), 64'd0);
        wb_rdy = 1'b1;
        step();
        drive(5'd1, 20'h0, 7'd61, 7'd1, 7'd2, 6'd5, 1, 0, 32'd0);
        step();

        // unused opcode: zero result, ROB ID still reported
        drive(5'd25, 20'hFFFFF, 7'd62, 7'd1, 7'd2, 6'h2A, 1, 1, 32'd0);
        step();
        ALU0_select_vld = 1'b0;

        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu0_exec_pipe.md
Name: alu0_exec_pipe

Overview:
- Consumer end of the ALU0 issue-queue select interface.
- Latches the instruction selected by the ALU0 issue queue, reads its physical-register operands with same-stage bypass, and executes a LoongArch32 integer ALU op.
- Returns the result through a writeback/ROB-complete handshake.
- Drives ALU0_IQ_pause back to the queue, and the ALU0 dest wakeup tag to all issue queues.

Parameters:
- PR_W, 7, physical register index width
- ROB_W, 6, ROB ID width
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush (branch mispredict / exception)
- ALU0_select_vld  in  1  selected instruction valid
- ALU0_select_op  in  5  ALU opcode
- ALU0_select_imm  in  20  immediate field
- ALU0_select_dest  in  PR_W  destination physical register
- ALU0_select_source1  in  PR_W  source 1 physical register
- ALU0_select_source2  in  PR_W  source 2 physical register
- ALU0_select_ROB_ID  in  ROB_W  ROB entry
- ALU0_IQ_pause  out  1  backpressure to the issue queue
- dest_ALU0_vld  out  1  wakeup broadcast valid
- dest_ALU0  out  PR_W  wakeup tag
- rf_raddr1, rf_raddr2  out  PR_W  regfile read addresses
- rf_rdata1, rf_rdata2  in  XLEN  regfile read data; asynchronous read, write-through
- wb_vld  out  1  writeback valid
- wb_rdy  in  1  writeback port accepts
- wb_dest  out  PR_W  writeback register
- wb_data  out  XLEN  result
- wb_ROB_ID  out  ROB_W  ROB entry to mark complete

Behaviour:
- Two stages:
  - S1 = register read and execute.
  - S2 = result register and writeback.
  - Each stage has its own valid bit.
- Reset: the rst edge clears s1_vld, s2_vld and all payload registers to 0. Every output is 0 after reset.
- Pause: ALU0_IQ_pause = s2_vld & !wb_rdy, combinational.
- S1 capture: S1 loads the select bus when ALU0_select_vld & !ALU0_IQ_pause & !flush. If there is no capture and S1 advances, s1_vld goes to 0. While paused, S1 and S2 hold and select_vld is ignored.
- S1 to S2 advance: S1 moves to S2 when s1_vld & !ALU0_IQ_pause. S2 clears when wb_vld & wb_rdy and nothing advances.
- Latency: select accepted at edge N gives wb_vld in cycle N+1, i.e. 2 cycles from select to writeback with no stall.
- Wakeup: dest_ALU0_vld = s1_vld & !ALU0_IQ_pause & !flush; dest_ALU0 = S1 dest. A dependent op selected in the same cycle picks up the result through the S2 bypass.
- Operand read: rf_raddr1/2 = S1 source1/2, always driven.
- Bypass:
  - If s2_vld and S2 dest equals the source, use wb_data instead of rf_rdata.
  - Bypass applies even when wb_rdy = 0.
  - A source of 0 is never bypassed.
- Operand select: opB = rdata2 for ops 0-10. Immediate ops (12-20) use the immediate.
- Opcodes and results (shift amounts use bits [4:0], unsigned):
  - 0 ADD, 1 SUB
  - 2 SLT (signed), 3 SLTU (unsigned)
  - 4 AND, 5 OR, 6 NOR, 7 XOR
  - 8 SLL, 9 SRL, 10 SRA
  - 11 LU12I = {imm[19:0], 12'b0}
  - 12 ADDI, 13 SLTI, 14 SLTUI: imm[11:0] sign-extended
  - 15 ANDI, 16 ORI, 17 XORI: imm[11:0] zero-extended
  - 18 SLLI, 19 SRLI, 20 SRAI: imm[4:0]
  - 21-31: result 0
- Arithmetic wraps modulo 2^32.
- Flush:
  - The flush edge clears s1_vld and s2_vld.
  - wb_vld and dest_ALU0_vld are gated low in the flush cycle itself.
  - A select in the flush cycle is dropped.
  - Flush has priority over pause and capture.
- Reset mid-operation: same effect as flush, and payloads are also cleared.
- A new select may be accepted in the same cycle S2 retires, giving full throughput of 1 op per cycle.

Test Plan:
- Back-to-back ops:
  - Stimulus: reset, then ADD (dest 5, src 1 = 10, src 2 = 3) with wb_rdy = 1, then ADDI (dest 6, src 5, imm 0xFFF) in the next cycle.
  - Required response: wb 5 = 13, then wb 6 = 12 via the bypass; dest_ALU0 = 5, then 6, on consecutive cycles.
- Opcode sweep:
  - Stimulus: A = 0x80000001, B = 0x00000004, covering SLT, SLTU, SRA, SRL, NOR, and LU12I with imm 0xABCDE.
  - Required response: 1, 0, 0xF8000000, 0x08000000, 0x7FFFFFFA, 0xABCDE000.
- Writeback stall:
  - Stimulus: hold wb_rdy = 0 for 3 cycles with 2 ops pending.
  - Required response: ALU0_IQ_pause = 1 and wb outputs stable throughout; select_vld is ignored; both ops retire in order once wb_rdy = 1.
- Flush:
  - Stimulus: flush with S1 and S2 both full, with a select present in the same cycle.
  - Required response: wb_vld = 0 that cycle and both stages empty afterward; the select is not captured.
- Reset mid-stall:
  - Stimulus: rst while paused.
  - Required response: all outputs 0 on the next cycle; a fresh op then completes normally.
- Unused opcodes:
  - Stimulus: opcode 25.
  - Required response: wb_data = 0, and wb_ROB_ID is still reported.
